// File: rtl/mux_n_1_stream_if.sv
// Stream bundle for the N:1 multiplexer: N producer channels in, one consumer out.
// The slave modport is the multiplexer's view and the master modport is the surrounding system's view.
interface mux_n_1_stream_if #(
    parameter int WIDTH = 16,
    parameter int N     = 16
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   selector;
    logic               mode;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   out_source;

    modport master (
        output in_data, in_valid, selector, mode, out_ready,
        input  in_ready, out_data, out_valid, out_source
    );

    modport slave (
        input  in_data, in_valid, selector, mode, out_ready,
        output in_ready, out_data, out_valid, out_source
    );
endinterface

// File: rtl/mux_n_1_stream.sv
// N:1 word multiplexer with valid/ready handshakes and one registered output stage.
// Fixed mode follows the selector; round-robin mode rotates fairly starting from an internal pointer.
module mux_n_1_stream #(
    parameter int WIDTH = 16,
    parameter int N     = 16
) (
    input logic            clock,
    input logic            reset,
    mux_n_1_stream_if.slave bus
);
    localparam int SEL_W = $clog2(N);
    localparam int SW1   = SEL_W + 1;
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);
    localparam logic [SW1-1:0]   N_EXT = SW1'(N);

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [SEL_W-1:0] source_q;
    logic [SEL_W-1:0] pointer_q;

    logic             load;
    logic             fixed_hit;
    logic [SEL_W-1:0] fixed_grant;
    logic             rr_hit;
    logic [SEL_W-1:0] rr_grant;
    logic [SW1-1:0]   idx;
    logic [SEL_W-1:0] cand;
    logic             grant_valid;
    logic [SEL_W-1:0] grant;
    logic [WIDTH-1:0] grant_word;
    logic [N-1:0]     ready_c;
    logic [SEL_W-1:0] pointer_next;

    assign load = !valid_q || bus.out_ready;

    // A selector value of N or above matches no channel, so it gives no grant.
    always_comb begin
        fixed_hit   = 1'b0;
        fixed_grant = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.selector == SEL_W'(i) && bus.in_valid[i]) begin
                fixed_hit   = 1'b1;
                fixed_grant = SEL_W'(i);
            end
        end
    end

    // Scan pointer, pointer+1, ... and wrap at N, which is not necessarily a power of two.
    always_comb begin
        rr_hit   = 1'b0;
        rr_grant = '0;
        idx      = '0;
        cand     = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, pointer_q} + SW1'(k);
            if (idx >= N_EXT) begin
                idx = idx - N_EXT;
            end
            cand = idx[SEL_W-1:0];
            if (!rr_hit && bus.in_valid[cand]) begin
                rr_hit   = 1'b1;
                rr_grant = cand;
            end
        end
    end

    assign grant_valid  = bus.mode ? rr_hit : fixed_hit;
    assign grant        = bus.mode ? rr_grant : fixed_grant;
    assign pointer_next = (grant == LAST) ? '0 : grant + 1'b1;

    always_comb begin
        grant_word = '0;
        ready_c    = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_word = bus.in_data[i*WIDTH +: WIDTH];
            end
            ready_c[i] = load && grant_valid && (grant == SEL_W'(i));
        end
    end

    // A load without a grant empties the stage but keeps the last word and source visible.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            source_q  <= '0;
            pointer_q <= '0;
        end else if (load) begin
            if (grant_valid) begin
                data_q   <= grant_word;
                source_q <= grant;
                valid_q  <= 1'b1;
                if (bus.mode) begin
                    pointer_q <= pointer_next;
                end
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = ready_c;
    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_source = source_q;
endmodule

// File: tb/tb_mux_n_1_stream.sv
// Self-checking bench for mux_n_1_stream: a 16-channel instance driven by a vector table,
// a round-robin sweep, an async reset and random traffic, plus a 5-channel instance for wrap cases.
module tb_mux_n_1_stream;
    logic clock = 1'b0;
    logic reset;
    logic reset5;

    always #5 clock = ~clock;

    mux_n_1_stream_if #(.WIDTH(16), .N(16)) bus16();
    mux_n_1_stream_if #(.WIDTH(8),  .N(5))  bus5();

    mux_n_1_stream #(.WIDTH(16), .N(16)) dut16 (
        .clock (clock),
        .reset (reset),
        .bus   (bus16)
    );

    mux_n_1_stream #(.WIDTH(8), .N(5)) dut5 (
        .clock (clock),
        .reset (reset5),
        .bus   (bus5)
    );

    typedef struct {
        logic [15:0] valid;
        logic [3:0]  sel;
        logic        md;
        logic        rdy;
        logic [15:0] exp_ready;
        logic        exp_ov;
        logic [3:0]  exp_src;
        logic [15:0] exp_data;
    } vec_t;

    vec_t vecs[10];

    int checks   = 0;
    int failures = 0;

    logic [15:0] words[16];
    logic [15:0] r_valid;
    logic [3:0]  r_sel;
    logic        r_md;
    logic        r_rdy;
    logic        m_valid;
    logic [15:0] m_data;
    int          m_src;
    int          m_ptr;
    int          g;
    int          cc;
    logic        ld;
    logic [15:0] exp_ready;

    function automatic logic [15:0] word16(input int i);
        return (i == 5) ? 16'hBEEF : 16'(16'h1000 + i * 16'h0101);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] valid, input logic [3:0] sel, input logic md, input logic rdy);
        bus16.in_valid  = valid;
        bus16.selector  = sel;
        bus16.mode      = md;
        bus16.out_ready = rdy;
    endtask

    task automatic loadWords16();
        for (int i = 0; i < 16; i++) begin
            bus16.in_data[i*16 +: 16] = words[i];
        end
    endtask

    task automatic step5(input string name, input logic [4:0] valid, input logic [2:0] sel, input logic md,
                         input logic rdy, input logic [4:0] exp_rdy, input logic exp_ov, input logic [2:0] exp_src,
                         input logic [7:0] exp_data);
        bus5.in_valid  = valid;
        bus5.selector  = sel;
        bus5.mode      = md;
        bus5.out_ready = rdy;
        #1;
        checkOutput({name, " in_ready"}, 32'(bus5.in_ready), 32'(exp_rdy));
        @(posedge clock);
        #1;
        checkOutput({name, " out_valid"}, 32'(bus5.out_valid), 32'(exp_ov));
        checkOutput({name, " out_source"}, 32'(bus5.out_source), 32'(exp_src));
        checkOutput({name, " out_data"}, 32'(bus5.out_data), 32'(exp_data));
    endtask

    initial begin
        // valid, sel, mode, out_ready | in_ready, out_valid, out_source, out_data after the edge
        vecs[0] = '{16'h0020, 4'd5,  1'b0, 1'b1, 16'h0020, 1'b1, 4'd5,  16'hBEEF};
        vecs[1] = '{16'hFFF7, 4'd3,  1'b0, 1'b1, 16'h0000, 1'b0, 4'd5,  16'hBEEF};
        vecs[2] = '{16'hFFF7, 4'd3,  1'b0, 1'b0, 16'h0000, 1'b0, 4'd5,  16'hBEEF};
        vecs[3] = '{16'h0004, 4'd2,  1'b0, 1'b0, 16'h0004, 1'b1, 4'd2,  16'h1202};
        vecs[4] = '{16'h0080, 4'd7,  1'b0, 1'b0, 16'h0000, 1'b1, 4'd2,  16'h1202};
        vecs[5] = '{16'h0080, 4'd7,  1'b0, 1'b0, 16'h0000, 1'b1, 4'd2,  16'h1202};
        vecs[6] = '{16'h0080, 4'd7,  1'b0, 1'b0, 16'h0000, 1'b1, 4'd2,  16'h1202};
        vecs[7] = '{16'h0080, 4'd7,  1'b0, 1'b1, 16'h0080, 1'b1, 4'd7,  16'h1707};
        vecs[8] = '{16'h0000, 4'd9,  1'b0, 1'b1, 16'h0000, 1'b0, 4'd7,  16'h1707};
        vecs[9] = '{16'h8000, 4'd15, 1'b0, 1'b1, 16'h8000, 1'b1, 4'd15, 16'h1F0F};

        reset  = 1'b1;
        reset5 = 1'b1;
        applyStimulus(16'h0000, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) words[i] = word16(i);
        loadWords16();
        bus5.in_valid  = '0;
        bus5.selector  = '0;
        bus5.mode      = 1'b0;
        bus5.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) bus5.in_data[i*8 +: 8] = 8'(8'hC0 + i);

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset out_valid", 32'(bus16.out_valid), 32'd0);
        checkOutput("reset out_data", 32'(bus16.out_data), 32'd0);
        checkOutput("reset out_source", 32'(bus16.out_source), 32'd0);
        reset  = 1'b0;
        reset5 = 1'b0;

        // Directed fixed-mode and backpressure vectors.
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].valid, vecs[v].sel, vecs[v].md, vecs[v].rdy);
            #1;
            checkOutput($sformatf("vec%0d in_ready", v), 32'(bus16.in_ready), 32'(vecs[v].exp_ready));
            @(posedge clock);
            #1;
            checkOutput($sformatf("vec%0d out_valid", v), 32'(bus16.out_valid), 32'(vecs[v].exp_ov));
            checkOutput($sformatf("vec%0d out_source", v), 32'(bus16.out_source), 32'(vecs[v].exp_src));
            checkOutput($sformatf("vec%0d out_data", v), 32'(bus16.out_data), 32'(vecs[v].exp_data));
        end

        // Round-robin sweep with every channel valid and no backpressure.
        applyStimulus(16'hFFFF, 4'd0, 1'b1, 1'b1);
        for (int k = 0; k < 17; k++) begin
            #1;
            checkOutput($sformatf("rr%0d in_ready", k), 32'(bus16.in_ready), 32'(16'h0001 << (k % 16)));
            @(posedge clock);
            #1;
            checkOutput($sformatf("rr%0d out_valid", k), 32'(bus16.out_valid), 32'd1);
            checkOutput($sformatf("rr%0d out_source", k), 32'(bus16.out_source), 32'(k % 16));
            checkOutput($sformatf("rr%0d out_data", k), 32'(bus16.out_data), 32'(word16(k % 16)));
        end

        // Reset in the middle of a held word acts without a clock edge.
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async reset out_valid", 32'(bus16.out_valid), 32'd0);
        checkOutput("async reset out_data", 32'(bus16.out_data), 32'd0);
        checkOutput("async reset out_source", 32'(bus16.out_source), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(16'hFFFF, 4'd0, 1'b1, 1'b0);
        #1;
        checkOutput("pointer after reset", 32'(bus16.in_ready), 32'h0001);
        applyStimulus(16'h0000, 4'd0, 1'b0, 1'b0);
        @(posedge clock);
        #1;

        // Random traffic against a queue-free reference of the output stage.
        m_valid = 1'b0;
        m_data  = '0;
        m_src   = 0;
        m_ptr   = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
            case ($urandom % 4)
                0:       r_valid = 16'h0000;
                1:       r_valid = 16'(16'h0001 << ($urandom % 16));
                default: r_valid = 16'($urandom);
            endcase
            r_sel = 4'($urandom % 16);
            r_md  = 1'($urandom % 2);
            r_rdy = (($urandom % 4) != 0);
            applyStimulus(r_valid, r_sel, r_md, r_rdy);
            loadWords16();
            #1;
            ld = !m_valid || r_rdy;
            g  = -1;
            if (!r_md) begin
                if (r_valid[r_sel]) g = int'(r_sel);
            end else begin
                for (int k = 0; k < 16; k++) begin
                    cc = (m_ptr + k) % 16;
                    if (g < 0 && r_valid[cc]) g = cc;
                end
            end
            exp_ready = (ld && g >= 0) ? (16'h0001 << g) : 16'h0000;
            checkOutput($sformatf("rand%0d in_ready", c), 32'(bus16.in_ready), 32'(exp_ready));
            if (ld) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = words[g];
                    m_src   = g;
                    if (r_md) m_ptr = (g + 1) % 16;
                end else begin
                    m_valid = 1'b0;
                end
            end
            @(posedge clock);
            #1;
            checkOutput($sformatf("rand%0d out_valid", c), 32'(bus16.out_valid), 32'(m_valid));
            checkOutput($sformatf("rand%0d out_source", c), 32'(bus16.out_source), 32'(m_src));
            checkOutput($sformatf("rand%0d out_data", c), 32'(bus16.out_data), 32'(m_data));
        end

        // Five channels: pointer wrap at N-1 and out-of-range selectors.
        step5("n5 prime",   5'b01000, 3'd0, 1'b1, 1'b1, 5'b01000, 1'b1, 3'd3, 8'hC3);
        step5("n5 rr a",    5'b10001, 3'd0, 1'b1, 1'b1, 5'b10000, 1'b1, 3'd4, 8'hC4);
        step5("n5 rr b",    5'b10001, 3'd0, 1'b1, 1'b1, 5'b00001, 1'b1, 3'd0, 8'hC0);
        step5("n5 rr c",    5'b10001, 3'd0, 1'b1, 1'b1, 5'b10000, 1'b1, 3'd4, 8'hC4);
        step5("n5 sel6",    5'b11111, 3'd6, 1'b0, 1'b1, 5'b00000, 1'b0, 3'd4, 8'hC4);
        step5("n5 sel7",    5'b11111, 3'd7, 1'b0, 1'b1, 5'b00000, 1'b0, 3'd4, 8'hC4);
        step5("n5 sel4",    5'b11111, 3'd4, 1'b0, 1'b1, 5'b10000, 1'b1, 3'd4, 8'hC4);
        step5("n5 stall",   5'b11111, 3'd0, 1'b1, 1'b0, 5'b00000, 1'b1, 3'd4, 8'hC4);
        step5("n5 resume",  5'b11111, 3'd0, 1'b1, 1'b1, 5'b00001, 1'b1, 3'd0, 8'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
